// File: rtl/core_pkg.sv
// Shared constants and types for the core's output-SRAM read path.
// Row geometry, the psum type, the drain FSM encoding and the ReLU clamp live here.
package core_pkg;

  localparam int COL       = 8;
  localparam int PSUM_BW   = 16;
  localparam int O_ADDR_BW = 4;
  localparam int ROW_BW    = COL * PSUM_BW;
  localparam int LANE_BW   = $clog2(COL);

  localparam logic [LANE_BW-1:0] LAST_LANE = LANE_BW'(COL - 1);

  typedef logic signed [PSUM_BW-1:0] psum_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    DRAIN,
    DONE
  } drain_state_e;

  // A negative psum is recognised purely by its sign bit.
  function automatic psum_t relu_clamp(input psum_t x, input logic en);
    return (en && x[PSUM_BW-1]) ? psum_t'(0) : x;
  endfunction

endpackage

// File: rtl/psum_drain.sv
// Host-side drain of the 128-bit output SRAM: reads rows 0..rows_m1 one at a time
// and streams each row's psums lane by lane on a valid/ready port, with optional ReLU.
module psum_drain
  import core_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [O_ADDR_BW-1:0] rows_m1,
  input  logic                 relu_en,
  output logic                 o_cen,
  output logic                 o_wen,
  output logic [O_ADDR_BW-1:0] o_addr,
  input  logic [ROW_BW-1:0]    o_q,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [PSUM_BW-1:0]   dout_data,
  output logic                 dout_last,
  output logic                 busy,
  output logic                 done
);

  drain_state_e          state_q, state_d;
  logic [O_ADDR_BW-1:0]  row_ptr_q, row_ptr_d;
  logic [O_ADDR_BW-1:0]  rows_m1_q, rows_m1_d;
  logic                  relu_q, relu_d;
  logic [LANE_BW-1:0]    lane_q, lane_d;
  logic [ROW_BW-1:0]     row_reg_q, row_reg_d;
  psum_t                 lane_psum;

  always_comb begin
    state_d   = state_q;
    row_ptr_d = row_ptr_q;
    rows_m1_d = rows_m1_q;
    relu_d    = relu_q;
    lane_d    = lane_q;
    row_reg_d = row_reg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rows_m1_d = rows_m1;
          relu_d    = relu_en;
          row_ptr_d = '0;
          state_d   = READ;
        end
      end
      READ:    state_d = CAPTURE;
      // The SRAM returns data one cycle after the READ edge, so it is captured here.
      CAPTURE: begin
        row_reg_d = o_q;
        lane_d    = '0;
        state_d   = DRAIN;
      end
      DRAIN: begin
        if (dout_ready) begin
          if (lane_q != LAST_LANE) begin
            lane_d = lane_q + 1'b1;
          end else if (row_ptr_q == rows_m1_q) begin
            state_d = DONE;
          end else begin
            row_ptr_d = row_ptr_q + 1'b1;
            state_d   = READ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      row_ptr_q <= '0;
      rows_m1_q <= '0;
      relu_q    <= 1'b0;
      lane_q    <= '0;
      row_reg_q <= '0;
    end else begin
      state_q   <= state_d;
      row_ptr_q <= row_ptr_d;
      rows_m1_q <= rows_m1_d;
      relu_q    <= relu_d;
      lane_q    <= lane_d;
      row_reg_q <= row_reg_d;
    end
  end

  // All outputs come from registered state, so valid never looks at ready.
  assign lane_psum  = row_reg_q[lane_q*PSUM_BW +: PSUM_BW];
  assign o_cen      = (state_q != READ);
  assign o_wen      = 1'b1;
  assign o_addr     = row_ptr_q;
  assign dout_valid = (state_q == DRAIN);
  assign dout_data  = dout_valid ? relu_clamp(lane_psum, relu_q) : '0;
  assign dout_last  = dout_valid && (lane_q == LAST_LANE) && (row_ptr_q == rows_m1_q);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule
